// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  // Borrow when b exceeds a, or when a==b and a borrow is already pending.
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: io_lhs - io_rhs - io_in_bin, one bit per cycle,
// LSB first, with valid/ready handshakes on operand and result sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic         io_in_bin,
  input  logic [N-1:0] io_lhs,
  input  logic [N-1:0] io_rhs,
  output logic         io_out_valid,
  input  logic         io_out_ready,
  output logic [N-1:0] io_out,
  output logic         io_bout
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e         state_q;
  logic [N-1:0]   lhs_sr_q;
  logic [N-1:0]   rhs_sr_q;
  logic [N-1:0]   result_q;
  logic [N-1:0]   out_q;
  logic [CW-1:0]  count_q;
  logic           borrow_q;
  logic           bout_q;
  logic           in_ready_q;
  logic           out_valid_q;

  logic           diff_d;
  logic           borrow_d;
  logic [N-1:0]   result_d;

  // Single cell reused every RUN cycle on the current LSBs and running borrow.
  full_subtractor_cell u_cell (
    .a_i    (lhs_sr_q[0]),
    .b_i    (rhs_sr_q[0]),
    .bin_i  (borrow_q),
    .d_o    (diff_d),
    .bout_o (borrow_d)
  );

  // Result register with the new difference bit entering at the MSB.
  always_comb begin
    // NOTE: assign a default first so every path drives result_d and no latch is inferred.
    result_d        = result_q >> 1;
    result_d[N-1]   = diff_d;
  end

  // Control FSM, operand shift registers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the operand/result shift registers are cleared too, so an aborted
      // operation leaves no residue behind.
      state_q     <= IDLE;
      lhs_sr_q    <= '0;
      rhs_sr_q    <= '0;
      result_q    <= '0;
      out_q       <= '0;
      count_q     <= '0;
      borrow_q    <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state_q)
        IDLE: begin
          if (io_in_valid && in_ready_q) begin
            lhs_sr_q   <= io_lhs;
            rhs_sr_q   <= io_rhs;
            borrow_q   <= io_in_bin;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          lhs_sr_q <= lhs_sr_q >> 1;
          rhs_sr_q <= rhs_sr_q >> 1;
          borrow_q <= borrow_d;
          result_q <= result_d;
          count_q  <= count_q + CW'(1);
          if (count_q == LAST) begin
            out_q       <= result_d;
            bout_q      <= borrow_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (io_out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign io_in_ready  = in_ready_q;
  assign io_out_valid = out_valid_q;
  assign io_out       = out_q;
  assign io_bout      = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial subtractor with borrow-in and borrow-out; the inverse operation of the team's combinational carry adder.
- Computes io_lhs - io_rhs - io_in_bin one bit per cycle, LSB first, through a 1-bit full-subtractor cell.
- Valid/ready handshakes on both sides, so it drops into pipelines where the adder's result must be undone or checked.

Parameters:
- N, 2, operand/result width in bits (N >= 1)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- io_in_valid  input  1  operand bundle valid
- io_in_ready  output  1  block can accept operands
- io_in_bin  input  1  borrow-in
- io_lhs  input  N  minuend
- io_rhs  input  N  subtrahend
- io_out_valid  output  1  result valid
- io_out_ready  input  1  consumer accepts result
- io_out  output  N  difference, (lhs - rhs - bin) mod 2^N
- io_bout  output  1  borrow-out, 1 iff lhs < rhs + bin (unsigned)

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; io_in_ready=1; io_out_valid=0; io_out=0; io_bout=0; internal shift registers, borrow and bit counter cleared. A reset mid-operation aborts the operation and discards it; no partial result is ever flagged valid.
- States: IDLE, RUN, DONE.
- IDLE:
  - io_in_ready=1.
  - On io_in_valid&&io_in_ready: latch lhs/rhs into shift registers, borrow<=io_in_bin, count<=0, go RUN.
- RUN:
  - io_in_ready=0, io_out_valid=0.
  - Each cycle, with a=lhs_sr[0], b=rhs_sr[0], br=borrow: d=a^b^br; borrow<=(~a&b)|(~(a^b)&br).
  - Shift d into result register MSB-first-in, so after N shifts bit i sits at position i.
  - Shift lhs_sr/rhs_sr right; count<=count+1.
  - When count==N-1 (last bit processed this cycle), go DONE.
- DONE:
  - io_out_valid=1; io_out=result; io_bout=final borrow.
  - Hold all outputs stable while io_out_ready=0.
  - On io_out_ready=1, go IDLE. io_in_ready rises the next cycle; a new acceptance cannot overlap the DONE handshake.
- Latency:
  - Operands accepted at edge t; io_out_valid asserted after edge t+N.
  - Minimum initiation interval N+2 cycles.
- Result visibility: io_out/io_bout hold the last result after the output handshake until the next result is loaded. They are meaningful only while io_out_valid=1.
- Width rules:
  - All arithmetic is unsigned modulo 2^N.
  - Counter width clog2(N+1).
  - N=1 is legal: RUN lasts exactly one cycle.
- Boundary cases:
  - lhs==rhs, bin=0: out=0, bout=0.
  - lhs=0, rhs=2^N-1, bin=1: out=0, bout=1 (full-range wrap).
  - io_in_valid asserted outside IDLE: ignored, operands not sampled.
  - io_out_ready asserted outside DONE: no effect.
- Relationship to the adder: for all inputs, feeding (out, bout) back through an adder with cin=bin and rhs restores lhs modulo 2^N; the carry-out equals bout.

Decomposition:
- Shared package serial_sub_pkg holds:
  - the state enum (IDLE=0, RUN=1, DONE=2, 2-bit encoding)
  - a width helper for the counter, clog2(N+1)
- One natural sub-module: full_subtractor_cell, purely combinational. Inputs a, b, bin; outputs d, bout. Instantiated once and reused each cycle.
- The FSM, shift registers and handshake logic live in serial_subtractor.

Test Plan:
1. N=2; lhs=2'b01, rhs=2'b10, bin=0, io_out_ready=1 -> io_out=2'b11, io_bout=1; io_out_valid high after edge t+2, for one cycle; io_in_ready high again the following cycle.
2. N=2; lhs=3, rhs=1, bin=1 -> io_out=1, io_bout=0. Then lhs=0, rhs=3, bin=1 -> io_out=0, io_bout=1.
3. N=8 backpressure; lhs=8'h10, rhs=8'h01, bin=0, io_out_ready low for 5 cycles -> io_out_valid held high, io_out=8'h0F, io_bout=0 stable throughout; io_in_ready=0; a concurrent io_in_valid pulse is ignored. Raise io_out_ready -> IDLE next cycle.
4. N=8; reset pulled low mid-RUN (after 3 bit-cycles) -> all outputs return to reset values immediately (asynchronous). After release, a fresh lhs=8'hFF, rhs=8'hFF, bin=0 yields io_out=0, io_bout=0 with no residue from the aborted operation.
5. N=1 corner; all 8 combinations of lhs, rhs, bin -> each produces the full-subtractor truth table (e.g. 0-1-1: d=0, bout=1), valid after exactly 1 RUN cycle.
6. N=8; 1000 random operand sets, random io_in_valid/io_out_ready gaps -> every result matches (lhs - rhs - bin) mod 256 and bout = (lhs < rhs + bin); adder round-trip restores lhs; no result lost or duplicated.
